// File: rtl/mem_port_sched_if.sv
// Bundle of the store, load and data-memory signals around the port scheduler.
// master drives requests (LSQ side); slave is the scheduler.
interface mem_port_sched_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          st_half;
  logic          st_ready;

  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [2:0]    ld_func3;
  logic [6:0]    ld_pd;
  logic [4:0]    ld_rob;
  logic          ld_ready;

  logic          mem_store_wb;
  logic [31:0]   mem_st_addr;
  logic [31:0]   mem_st_data;
  logic          mem_st_half;
  logic          mem_load;
  logic [31:0]   mem_ld_addr;
  logic [2:0]    mem_ld_func3;
  logic [6:0]    mem_ld_pd;
  logic [4:0]    mem_ld_rob;
  logic [CW-1:0] sq_count;

  modport master (
    output st_valid, st_addr, st_data, st_half,
    output ld_valid, ld_addr, ld_func3, ld_pd, ld_rob,
    input  st_ready, ld_ready,
    input  mem_store_wb, mem_st_addr, mem_st_data, mem_st_half,
    input  mem_load, mem_ld_addr, mem_ld_func3, mem_ld_pd, mem_ld_rob,
    input  sq_count
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_half,
    input  ld_valid, ld_addr, ld_func3, ld_pd, ld_rob,
    output st_ready, ld_ready,
    output mem_store_wb, mem_st_addr, mem_st_data, mem_st_half,
    output mem_load, mem_ld_addr, mem_ld_func3, mem_ld_pd, mem_ld_rob,
    output sq_count
  );
endinterface

// File: rtl/mem_port_sched.sv
// Single data-memory port scheduler: committed-store FIFO arbitrated against loads,
// with forced drain on full queue, store starvation, and load/store overlap.
module mem_port_sched #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_sched_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {NORMAL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [DEPTH-1:0] valid_q;

  logic [31:0]     addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [DEPTH-1:0] half_q;

  logic            mem_store_wb_q;
  logic [31:0]     mem_st_addr_q;
  logic [31:0]     mem_st_data_q;
  logic            mem_st_half_q;
  logic            mem_load_q;
  logic [31:0]     mem_ld_addr_q;
  logic [2:0]      mem_ld_func3_q;
  logic [6:0]      mem_ld_pd_q;
  logic [4:0]      mem_ld_rob_q;

  logic            st_ready;
  logic            ld_ready;
  logic            push;
  logic            pop;
  logic            ld_issue;
  logic            conflict;
  logic [DEPTH-1:0] hit;
  logic [32:0]     ld_end;

  // Ranges are compared at 33 bits so a range ending past 0xFFFFFFFF never wraps.
  assign ld_end = {1'b0, bus.ld_addr} + ((bus.ld_func3 == 3'b100) ? 33'd1 : 33'd4);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_overlap
    logic [32:0] st_end;
    assign st_end  = {1'b0, addr_q[gi]} + (half_q[gi] ? 33'd2 : 33'd4);
    assign hit[gi] = valid_q[gi]
                     && ({1'b0, bus.ld_addr} < st_end)
                     && ({1'b0, addr_q[gi]} < ld_end);
  end

  assign conflict = |hit;

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    tail_d   = tail_q;
    starve_d = starve_q;
    ld_ready = 1'b0;
    ld_issue = 1'b0;
    pop      = 1'b0;
    st_ready = (count_q < CW'(DEPTH));
    push     = bus.st_valid && st_ready;

    if (state_q == NORMAL) begin
      ld_ready = reset && !conflict;
      ld_issue = bus.ld_valid && ld_ready;
      pop      = !ld_issue && (count_q != '0);
    end else begin
      pop      = (count_q != '0);
    end

    count_d = count_q + CW'(push) - CW'(pop);
    if (pop)  head_d = head_q + PW'(1);
    if (push) tail_d = tail_q + PW'(1);

    if (pop || count_q == '0) begin
      starve_d = '0;
    end else if (ld_issue && starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end

    // Uses next-state values so the STARVE_MAX-th load is the last one let through.
    case (state_q)
      NORMAL: if (count_d == CW'(DEPTH) || starve_d == SW'(STARVE_MAX)) state_d = DRAIN;
      DRAIN:  if (count_d == '0) state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= NORMAL;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      starve_q       <= '0;
      valid_q        <= '0;
      mem_store_wb_q <= 1'b0;
      mem_st_addr_q  <= '0;
      mem_st_data_q  <= '0;
      mem_st_half_q  <= 1'b0;
      mem_load_q     <= 1'b0;
      mem_ld_addr_q  <= '0;
      mem_ld_func3_q <= '0;
      mem_ld_pd_q    <= '0;
      mem_ld_rob_q   <= '0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      if (push) valid_q[tail_q] <= 1'b1;
      if (pop)  valid_q[head_q] <= 1'b0;

      mem_store_wb_q <= pop;
      mem_st_addr_q  <= pop ? addr_q[head_q] : '0;
      mem_st_data_q  <= pop ? data_q[head_q] : '0;
      mem_st_half_q  <= pop ? half_q[head_q] : 1'b0;

      mem_load_q     <= ld_issue;
      mem_ld_addr_q  <= ld_issue ? bus.ld_addr  : '0;
      mem_ld_func3_q <= ld_issue ? bus.ld_func3 : '0;
      mem_ld_pd_q    <= ld_issue ? bus.ld_pd    : '0;
      mem_ld_rob_q   <= ld_issue ? bus.ld_rob   : '0;
    end
  end

  // Entry payload needs no reset; valid_q alone decides occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
      half_q[tail_q] <= bus.st_half;
    end
  end

  assign bus.st_ready     = st_ready;
  assign bus.ld_ready     = ld_ready;
  assign bus.mem_store_wb = mem_store_wb_q;
  assign bus.mem_st_addr  = mem_st_addr_q;
  assign bus.mem_st_data  = mem_st_data_q;
  assign bus.mem_st_half  = mem_st_half_q;
  assign bus.mem_load     = mem_load_q;
  assign bus.mem_ld_addr  = mem_ld_addr_q;
  assign bus.mem_ld_func3 = mem_ld_func3_q;
  assign bus.mem_ld_pd    = mem_ld_pd_q;
  assign bus.mem_ld_rob   = mem_ld_rob_q;
  assign bus.sq_count     = count_q;
endmodule

// File: tb/tb_mem_port_sched.sv
// Directed testbench for mem_port_sched: reset, issue ordering, overlap, drain,
// starvation and mid-drain reset scenarios with hand-computed expectations.
module tb_mem_port_sched;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  typedef struct packed {
    logic [31:0] sa;
    logic        sh;
    logic [31:0] la;
    logic [2:0]  f3;
    logic        rdy;
  } ov_t;

  ov_t ov_tab [6] = '{
    '{32'h0000_0300, 1'b0, 32'h0000_0304, 3'b100, 1'b1},
    '{32'h0000_0300, 1'b0, 32'h0000_0303, 3'b100, 1'b0},
    '{32'h0000_0200, 1'b1, 32'h0000_0202, 3'b010, 1'b1},
    '{32'h0000_0200, 1'b1, 32'h0000_01FE, 3'b010, 1'b0},
    '{32'h0000_0300, 1'b0, 32'h0000_02FC, 3'b010, 1'b1},
    '{32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 3'b100, 1'b0}
  };

  mem_port_sched_if #(.DEPTH(4)) bus ();

  mem_port_sched #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.ld_valid = 1'b1;
    bus.ld_addr  = 32'h40;
    tick(); tick();
    checks++; if (bus.mem_store_wb !== 1'b0) begin failures++; $display("FAIL rst_store_wb got=%0b exp=0", bus.mem_store_wb); end
    checks++; if (bus.mem_load !== 1'b0) begin failures++; $display("FAIL rst_load got=%0b exp=0", bus.mem_load); end
    checks++; if (bus.mem_st_addr !== 32'h0) begin failures++; $display("FAIL rst_st_addr got=%h exp=0", bus.mem_st_addr); end
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL rst_st_ready got=%0b exp=1", bus.st_ready); end
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ld_ready got=%0b exp=0", bus.ld_ready); end
    checks++; if (bus.sq_count !== 3'd0) begin failures++; $display("FAIL rst_sq_count got=%0d exp=0", bus.sq_count); end
    bus.ld_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ld_ready got=%0b exp=1", bus.ld_ready); end
    $display("test_reset done");
  endtask

  task automatic test_store_basic(input logic [31:0] addr, input logic [31:0] data);
    bus.st_valid = 1'b1; bus.st_addr = addr; bus.st_data = data; bus.st_half = 1'b0;
    #1;
    checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL basic_st_ready got=%0b exp=1", bus.st_ready); end
    tick();
    bus.st_valid = 1'b0;
    checks++; if (bus.sq_count !== 3'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", bus.sq_count); end
    checks++; if (bus.mem_store_wb !== 1'b0) begin failures++; $display("FAIL basic_early_wb got=%0b exp=0", bus.mem_store_wb); end
    tick();
    checks++; if (bus.mem_store_wb !== 1'b1) begin failures++; $display("FAIL basic_wb got=%0b exp=1", bus.mem_store_wb); end
    checks++; if (bus.mem_st_addr !== addr) begin failures++; $display("FAIL basic_addr got=%h exp=%h", bus.mem_st_addr, addr); end
    checks++; if (bus.mem_st_data !== data) begin failures++; $display("FAIL basic_data got=%h exp=%h", bus.mem_st_data, data); end
    checks++; if (bus.mem_st_half !== 1'b0) begin failures++; $display("FAIL basic_half got=%0b exp=0", bus.mem_st_half); end
    checks++; if (bus.sq_count !== 3'd0) begin failures++; $display("FAIL basic_count0 got=%0d exp=0", bus.sq_count); end
    tick();
    checks++; if (bus.mem_store_wb !== 1'b0) begin failures++; $display("FAIL basic_wb_one_cycle got=%0b exp=0", bus.mem_store_wb); end
    $display("test_store_basic addr=%h data=%h done", addr, data);
  endtask

  task automatic test_conflict;
    bus.st_valid = 1'b1; bus.st_addr = 32'h200; bus.st_data = 32'h1234; bus.st_half = 1'b1;
    tick();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h201; bus.ld_func3 = 3'b010; bus.ld_pd = 7'h15; bus.ld_rob = 5'h0A;
    #1;
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL conf_blocked got=%0b exp=0", bus.ld_ready); end
    tick();
    checks++; if (bus.mem_store_wb !== 1'b1) begin failures++; $display("FAIL conf_store_first got=%0b exp=1", bus.mem_store_wb); end
    checks++; if (bus.mem_st_half !== 1'b1) begin failures++; $display("FAIL conf_half got=%0b exp=1", bus.mem_st_half); end
    checks++; if (bus.mem_load !== 1'b0) begin failures++; $display("FAIL conf_no_load got=%0b exp=0", bus.mem_load); end
    checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL conf_unblocked got=%0b exp=1", bus.ld_ready); end
    tick();
    bus.ld_valid = 1'b0;
    checks++; if (bus.mem_load !== 1'b1) begin failures++; $display("FAIL conf_load got=%0b exp=1", bus.mem_load); end
    checks++; if (bus.mem_ld_addr !== 32'h201) begin failures++; $display("FAIL conf_ld_addr got=%h exp=201", bus.mem_ld_addr); end
    checks++; if (bus.mem_ld_pd !== 7'h15) begin failures++; $display("FAIL conf_pd got=%h exp=15", bus.mem_ld_pd); end
    checks++; if (bus.mem_ld_rob !== 5'h0A) begin failures++; $display("FAIL conf_rob got=%h exp=0a", bus.mem_ld_rob); end
    checks++; if (bus.mem_ld_func3 !== 3'b010) begin failures++; $display("FAIL conf_func3 got=%b exp=010", bus.mem_ld_func3); end
    tick();
    checks++; if (bus.mem_load !== 1'b0) begin failures++; $display("FAIL conf_load_one_cycle got=%0b exp=0", bus.mem_load); end
    $display("test_conflict done");
  endtask

  task automatic test_overlap_table;
    for (int r = 0; r < 6; r++) begin
      bus.st_valid = 1'b1; bus.st_addr = ov_tab[r].sa; bus.st_data = 32'h5A00 + r; bus.st_half = ov_tab[r].sh;
      tick();
      bus.st_valid = 1'b0;
      bus.ld_valid = 1'b1; bus.ld_addr = ov_tab[r].la; bus.ld_func3 = ov_tab[r].f3; bus.ld_pd = 7'(r); bus.ld_rob = 5'(r);
      #1;
      checks++; if (bus.ld_ready !== ov_tab[r].rdy) begin failures++; $display("FAIL ovl_ready row=%0d got=%0b exp=%0b", r, bus.ld_ready, ov_tab[r].rdy); end
      tick();
      bus.ld_valid = 1'b0;
      checks++; if (bus.mem_load !== ov_tab[r].rdy) begin failures++; $display("FAIL ovl_first_load row=%0d got=%0b exp=%0b", r, bus.mem_load, ov_tab[r].rdy); end
      checks++; if (bus.mem_store_wb !== !ov_tab[r].rdy) begin failures++; $display("FAIL ovl_first_store row=%0d got=%0b exp=%0b", r, bus.mem_store_wb, !ov_tab[r].rdy); end
      tick();
      if (ov_tab[r].rdy) begin
        checks++; if (bus.mem_store_wb !== 1'b1) begin failures++; $display("FAIL ovl_store_after_load row=%0d got=%0b exp=1", r, bus.mem_store_wb); end
      end
      checks++; if (bus.sq_count !== 3'd0) begin failures++; $display("FAIL ovl_empty row=%0d got=%0d exp=0", r, bus.sq_count); end
      $display("test_overlap_table row=%0d st=%h ld=%h ready_exp=%0b", r, ov_tab[r].sa, ov_tab[r].la, ov_tab[r].rdy);
    end
  endtask

  task automatic test_unsupported_func3;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h800; bus.ld_func3 = 3'b111; bus.ld_pd = 7'h7F; bus.ld_rob = 5'h1F;
    #1;
    checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL f3_ready got=%0b exp=1", bus.ld_ready); end
    tick();
    bus.ld_valid = 1'b0;
    checks++; if (bus.mem_load !== 1'b1) begin failures++; $display("FAIL f3_load got=%0b exp=1", bus.mem_load); end
    checks++; if (bus.mem_ld_func3 !== 3'b111) begin failures++; $display("FAIL f3_func3 got=%b exp=111", bus.mem_ld_func3); end
    checks++; if (bus.mem_ld_pd !== 7'h7F) begin failures++; $display("FAIL f3_pd got=%h exp=7f", bus.mem_ld_pd); end
    tick();
    $display("test_unsupported_func3 done");
  endtask

  task automatic test_back_to_back;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h1000; bus.ld_func3 = 3'b010; bus.ld_pd = 7'h03; bus.ld_rob = 5'h04;
    for (int i = 0; i < 4; i++) begin
      bus.st_valid = 1'b1; bus.st_addr = 32'h400 + 32'(4 * i); bus.st_data = 32'hA0 + 32'(i); bus.st_half = 1'b0;
      #1;
      checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL b2b_st_ready i=%0d got=%0b exp=1", i, bus.st_ready); end
      checks++; if (bus.ld_ready !== 1'b1) begin failures++; $display("FAIL b2b_ld_ready i=%0d got=%0b exp=1", i, bus.ld_ready); end
      tick();
    end
    bus.st_addr = 32'h500;
    #1;
    checks++; if (bus.sq_count !== 3'd4) begin failures++; $display("FAIL b2b_full got=%0d exp=4", bus.sq_count); end
    checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL b2b_drain_ld got=%0b exp=0", bus.ld_ready); end
    checks++; if (bus.st_ready !== 1'b0) begin failures++; $display("FAIL b2b_full_st_ready got=%0b exp=0", bus.st_ready); end
    checks++; if (bus.mem_load !== 1'b1) begin failures++; $display("FAIL b2b_last_load got=%0b exp=1", bus.mem_load); end
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.st_valid = 1'b0;
      checks++; if (bus.mem_store_wb !== 1'b1) begin failures++; $display("FAIL b2b_wb k=%0d got=%0b exp=1", k, bus.mem_store_wb); end
      checks++; if (bus.mem_st_addr !== 32'h400 + 32'(4 * k)) begin failures++; $display("FAIL b2b_addr k=%0d got=%h exp=%h", k, bus.mem_st_addr, 32'h400 + 32'(4 * k)); end
      checks++; if (bus.mem_load !== 1'b0) begin failures++; $display("FAIL b2b_no_load k=%0d got=%0b exp=0", k, bus.mem_load); end
      checks++; if (bus.sq_count !== 3'(3 - k)) begin failures++; $display("FAIL b2b_count k=%0d got=%0d exp=%0d", k, bus.sq_count, 3 - k); end
      checks++; if (bus.ld_ready !== (k == 3)) begin failures++; $display("FAIL b2b_ld_ready k=%0d got=%0b exp=%0b", k, bus.ld_ready, k == 3); end
    end
    tick();
    bus.ld_valid = 1'b0;
    checks++; if (bus.mem_load !== 1'b1) begin failures++; $display("FAIL b2b_resume_load got=%0b exp=1", bus.mem_load); end
    checks++; if (bus.mem_store_wb !== 1'b0) begin failures++; $display("FAIL b2b_resume_no_wb got=%0b exp=0", bus.mem_store_wb); end
    tick();
    $display("test_back_to_back done");
  endtask

  task automatic test_starve;
    int loads_before = 0;
    int store_tick   = 0;
    int both_high    = 0;
    logic load_at_10 = 1'b0;
    bus.st_valid = 1'b1; bus.st_addr = 32'h600; bus.st_data = 32'h66; bus.st_half = 1'b0;
    tick();
    bus.st_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h700; bus.ld_func3 = 3'b100; bus.ld_pd = 7'h09; bus.ld_rob = 5'h02;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (bus.mem_load && bus.mem_store_wb) both_high++;
      if (bus.mem_load && store_tick == 0) loads_before++;
      if (bus.mem_store_wb && store_tick == 0) store_tick = j;
      if (j == 10) load_at_10 = bus.mem_load;
      if (j == 8) begin
        checks++; if (bus.ld_ready !== 1'b0) begin failures++; $display("FAIL starve_drain_ld_ready got=%0b exp=0", bus.ld_ready); end
      end
    end
    bus.ld_valid = 1'b0;
    tick();
    checks++; if (loads_before != 8) begin failures++; $display("FAIL starve_loads got=%0d exp=8", loads_before); end
    checks++; if (store_tick != 9) begin failures++; $display("FAIL starve_store_tick got=%0d exp=9", store_tick); end
    checks++; if (load_at_10 !== 1'b1) begin failures++; $display("FAIL starve_resume got=%0b exp=1", load_at_10); end
    checks++; if (both_high != 0) begin failures++; $display("FAIL starve_exclusive got=%0d exp=0", both_high); end
    $display("test_starve loads=%0d store_tick=%0d", loads_before, store_tick);
  endtask

  task automatic test_reset_mid;
    int wb_seen = 0;
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h900; bus.ld_func3 = 3'b010; bus.ld_pd = 7'h01; bus.ld_rob = 5'h01;
    for (int i = 0; i < 3; i++) begin
      bus.st_valid = 1'b1; bus.st_addr = 32'hA00 + 32'(4 * i); bus.st_data = 32'(i); bus.st_half = 1'b0;
      tick();
    end
    bus.st_valid = 1'b0;
    #1;
    checks++; if (bus.sq_count !== 3'd3) begin failures++; $display("FAIL rmid_count3 got=%0d exp=3", bus.sq_count); end
    reset = 1'b0;
    bus.ld_valid = 1'b0;
    #1;
    checks++; if (bus.sq_count !== 3'd0) begin failures++; $display("FAIL rmid_async_count got=%0d exp=0", bus.sq_count); end
    checks++; if (bus.mem_load !== 1'b0) begin failures++; $display("FAIL rmid_async_load got=%0b exp=0", bus.mem_load); end
    tick(); tick();
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (bus.mem_store_wb) wb_seen++;
    end
    checks++; if (wb_seen != 0) begin failures++; $display("FAIL rmid_no_wb got=%0d exp=0", wb_seen); end
    checks++; if (bus.sq_count !== 3'd0) begin failures++; $display("FAIL rmid_count0 got=%0d exp=0", bus.sq_count); end
    $display("test_reset_mid done");
    test_store_basic(32'h104, 32'hCAFEF00D);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_half = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_func3 = '0; bus.ld_pd = '0; bus.ld_rob = '0;
    test_reset();
    test_store_basic(32'h100, 32'hDEADBEEF);
    test_conflict();
    test_overlap_table();
    test_unsupported_func3();
    test_back_to_back();
    test_starve();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
